// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a
// line-wide memory. Hits finish in the issuing cycle; misses freeze the pipeline.
//
// state     | meaning
// IDLE      | serve hits; a miss raises stall and picks WRITEBACK or ALLOCATE
// WRITEBACK | write the dirty victim line back to memory
// ALLOCATE  | fetch the requested line; the frozen request then hits in IDLE
module dcache_controller #(
    parameter int LINES      = 16,
    parameter int LINE_BYTES = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_W-1:0]       cpu_addr_i,
    input  logic [31:0]             cpu_data_i,
    output logic [31:0]             cpu_data_o,
    output logic                    cpu_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_data_o,
    input  logic                    mem_ack_i,
    input  logic [8*LINE_BYTES-1:0] mem_data_i
);
    localparam int LINE_W   = 8 * LINE_BYTES;
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(LINE_BYTES);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WSEL_W   = OFFSET_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    state_t state_next;

    logic [LINE_W-1:0]  data_arr [LINES];
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [WSEL_W-1:0]  wsel;
    logic               hit;
    logic               store_hit;
    logic               fill;
    logic               unused_bits;

    assign index       = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = cpu_addr_i[OFFSET_W-1:2];
    assign unused_bits = ^cpu_addr_i[1:0];
    assign hit         = cpu_req_i & valid[index] & (tag_arr[index] == tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (store_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    // Line storage carries no reset; only valid/dirty decide whether it is used.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_arr[index] <= mem_data_i;
            tag_arr[index]  <= tag;
        end else if (store_hit) begin
            data_arr[index][{wsel, 5'b00000} +: 32] <= cpu_data_i;
        end
    end

    always_comb begin
        state_next  = state;
        cpu_stall_o = 1'b0;
        cpu_data_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        store_hit   = 1'b0;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (cpu_we_i) begin
                            store_hit = 1'b1;
                        end else begin
                            cpu_data_o = data_arr[index][{wsel, 5'b00000} +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_next  = (valid[index] & dirty[index]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_arr[index], index, {OFFSET_W{1'b0}}};
                mem_data_o  = data_arr[index];
                if (mem_ack_i) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag, index, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios and random traffic, checked each cycle
// against a transaction-level cache + memory model.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_i = '0;

    int tests = 0;
    int fails = 0;
    int lat_w = 1;
    int lat_f = 1;
    bit spurious = 1'b0;

    logic [255:0] mem [logic [31:0]];

    dcache_controller dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mem_get(input logic [31:0] a);
        logic [255:0] l;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = a ^ (32'(w) << 24) ^ 32'hC0DE_0000;
        return l;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Memory side: ack after the chosen number of request cycles, forget on reset.
    int rcnt = 0;
    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (rst_i) begin
            rcnt = 0;
        end else if (mem_req_o) begin
            rcnt++;
            if (rcnt >= (mem_we_o ? lat_w : lat_f)) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_we_o ? '0 : mem_get(mem_addr_o);
                rcnt = 0;
            end
        end else begin
            rcnt = 0;
            if (spurious) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{$urandom}};
                spurious   = 1'b0;
            end
        end
    end

    // Reference model: per access, predict memory transactions and stall length.
    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] data;
    } tx_t;

    logic         m_valid [16];
    logic         m_dirty [16];
    logic [22:0]  m_tag   [16];
    logic [255:0] m_line  [16];
    tx_t          exp_q[$];
    bit           in_acc = 1'b0;
    int           exp_stall = 0;
    int           stall_cnt = 0;
    logic [3:0]   c_idx;
    logic [22:0]  c_tag;
    logic [2:0]   c_wsel;
    logic         c_hit;

    always @(negedge clk) begin
        #1;
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            exp_q.delete();
            in_acc = 1'b0;
        end else if (!cpu_req_i) begin
            in_acc = 1'b0;
            exp_q.delete();
            check1("idle_stall", cpu_stall_o, 1'b0);
            check1("idle_mem_req", mem_req_o, 1'b0);
            check32("idle_rdata", cpu_data_o, 32'h0);
        end else begin
            if (!in_acc) begin
                c_idx  = cpu_addr_i[8:5];
                c_tag  = cpu_addr_i[31:9];
                c_wsel = cpu_addr_i[4:2];
                c_hit  = m_valid[c_idx] && (m_tag[c_idx] == c_tag);
                exp_q.delete();
                stall_cnt = 0;
                exp_stall = 0;
                if (!c_hit) begin
                    exp_stall = 1 + lat_f;
                    if (m_valid[c_idx] && m_dirty[c_idx]) begin
                        exp_q.push_back('{1'b1, {m_tag[c_idx], c_idx, 5'b0}, m_line[c_idx]});
                        exp_stall += lat_w;
                    end
                    exp_q.push_back('{1'b0, {c_tag, c_idx, 5'b0}, 256'h0});
                end
                in_acc = 1'b1;
            end
            if (cpu_stall_o) stall_cnt++;
            if (mem_req_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_req: got mem_req_o=1 addr %h, required 0", mem_addr_o);
                end else begin
                    check1("mem_we", mem_we_o, exp_q[0].we);
                    check32("mem_addr", mem_addr_o, exp_q[0].addr);
                    if (exp_q[0].we) check256("mem_wdata", mem_data_o, exp_q[0].data);
                    if (mem_ack_i) begin
                        if (exp_q[0].we) begin
                            mem[exp_q[0].addr] = exp_q[0].data;
                        end else begin
                            m_line[c_idx]  = mem_get(exp_q[0].addr);
                            m_tag[c_idx]   = c_tag;
                            m_valid[c_idx] = 1'b1;
                            m_dirty[c_idx] = 1'b0;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!cpu_stall_o) begin
                check_int("stall_cycles", stall_cnt, exp_stall);
                check_int("pending_mem_txns", exp_q.size(), 0);
                if (cpu_we_i) begin
                    m_line[c_idx][c_wsel*32 +: 32] = cpu_data_i;
                    m_dirty[c_idx] = 1'b1;
                end else begin
                    check32("load_data", cpu_data_o, m_line[c_idx][c_wsel*32 +: 32]);
                end
                in_acc = 1'b0;
            end
        end
    end

    logic [31:0] tx_addr [2];
    logic        tx_we   [2];
    logic [31:0] tx_w1   [2];
    int          ntx;

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input int lw, input int lf, output int stalls, output logic [31:0] rdata);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        lat_w = lw;
        lat_f = lf;
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        stalls = 0;
        rdata  = '0;
        ntx    = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (mem_req_o && mem_ack_i && ntx < 2) begin
                tx_addr[ntx] = mem_addr_o;
                tx_we[ntx]   = mem_we_o;
                tx_w1[ntx]   = mem_data_o[63:32];
                ntx++;
            end
            if (cpu_stall_o) stalls++;
            else begin
                rdata = cpu_data_o;
                done  = 1'b1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: cpu_stall_o still 1 after 200 cycles at addr %h, required 0", addr);
        end
    endtask

    task automatic idle(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cpu_req_i = 1'b0;
            if (rnd) begin
                cpu_addr_i = $urandom;
                cpu_we_i   = ($urandom % 2) == 1;
                cpu_data_i = $urandom;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        logic [31:0] a;
        logic [255:0] l100, l300;
        bit          got;

        for (int w = 0; w < 8; w++) begin
            l100[w*32 +: 32] = 32'h1111_1111 * w;
            l300[w*32 +: 32] = 32'h3000_0000 + w;
        end
        mem[32'h100] = l100;
        mem[32'h300] = l300;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        check1("reset_stall", cpu_stall_o, 1'b0);
        check1("reset_mem_req", mem_req_o, 1'b0);

        // 1: clean miss with Lf = 10
        do_access(1'b0, 32'h104, 32'h0, 1, 10, st, rd);
        check_int("t1_stalls", st, 11);
        check32("t1_mem_addr", tx_addr[0], 32'h100);
        check1("t1_mem_we", tx_we[0], 1'b0);
        check32("t1_rdata", rd, 32'h1111_1111);

        // 2: store hit, then load hits
        do_access(1'b1, 32'h104, 32'hDEAD_BEEF, 1, 1, st, rd);
        check_int("t2_store_stalls", st, 0);
        do_access(1'b0, 32'h104, 32'h0, 1, 1, st, rd);
        check_int("t2_load_stalls", st, 0);
        check32("t2_rdata_104", rd, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h108, 32'h0, 1, 1, st, rd);
        check32("t2_rdata_108", rd, 32'h2222_2222);

        // 3: dirty conflict miss at index 8
        do_access(1'b0, 32'h304, 32'h0, 4, 3, st, rd);
        check_int("t3_stalls", st, 8);
        check1("t3_wb_we", tx_we[0], 1'b1);
        check32("t3_wb_addr", tx_addr[0], 32'h100);
        check32("t3_wb_word1", tx_w1[0], 32'hDEAD_BEEF);
        check32("t3_fetch_addr", tx_addr[1], 32'h300);
        check32("t3_rdata", rd, 32'h3000_0001);

        // 4: reset while fetching
        @(posedge clk);
        #1;
        lat_w = 20;
        lat_f = 20;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h104;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1;
            if (mem_req_o) got = 1'b1;
        end
        check1("t4_reached_fetch", got, 1'b1);
        check1("t4_fetch_we", mem_we_o, 1'b0);
        pulse_reset();
        @(negedge clk);
        #1;
        check1("t4_req_after_rst", mem_req_o, 1'b0);
        check1("t4_stall_after_rst", cpu_stall_o, 1'b0);
        do_access(1'b0, 32'h104, 32'h0, 1, 3, st, rd);
        check_int("t4_miss_again_stalls", st, 4);
        check32("t4_rdata", rd, 32'hDEAD_BEEF);

        // 5: idle bus with random addresses leaves the cache alone
        idle(20, 1'b1);
        do_access(1'b0, 32'h104, 32'h0, 1, 1, st, rd);
        check_int("t5_hit_stalls", st, 0);
        check32("t5_rdata_104", rd, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h108, 32'h0, 1, 1, st, rd);
        check32("t5_rdata_108", rd, 32'h2222_2222);

        // 6: ack in the first request cycle, then a stray ack while idle
        l100 = mem_get(32'h2040);
        do_access(1'b0, 32'h2040, 32'h0, 1, 1, st, rd);
        check_int("t6_stalls", st, 2);
        check32("t6_rdata", rd, l100[31:0]);
        idle(1, 1'b0);
        spurious = 1'b1;
        idle(3, 1'b0);
        do_access(1'b0, 32'h2040, 32'h0, 1, 1, st, rd);
        check_int("t6_hit_after_stray_ack", st, 0);
        check32("t6_rdata_after_stray_ack", rd, l100[31:0]);

        // random traffic over a few tags per index
        for (int n = 0; n < 300; n++) begin
            a = (($urandom % 4 == 3) ? 32'h7F_FFFF : 32'($urandom_range(0, 2))) << 9;
            a = a | (32'($urandom_range(0, 15)) << 5) | (32'($urandom_range(0, 7)) << 2)
                  | 32'($urandom_range(0, 3));
            do_access(($urandom % 2) == 1, a, $urandom, $urandom_range(1, 5), $urandom_range(1, 5), st, rd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b1);
            if ($urandom_range(0, 59) == 0) pulse_reset();
        end
        idle(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
